// File: rtl/rvfi_shadow_pkg.sv
// rtl/rvfi_shadow_pkg.sv - shared types and constants for the RVFI shadow pipeline
//
// Holds the per-stage entry layout (valid bit, issue-side fields, memory-side
// fields) sized by SHADOW_XLEN, and the retirement order counter width.
// The top-level XLEN parameter defaults to SHADOW_XLEN and must match it.

package rvfi_shadow_pkg;

  localparam int ORDER_W       = 64;
  localparam int SHADOW_XLEN   = 32;
  localparam int SHADOW_MASK_W = SHADOW_XLEN / 8;

  // Memory-side fields, overwritten as a group at the memory stage.
  typedef struct packed {
    logic [SHADOW_XLEN-1:0]   addr;
    logic [SHADOW_XLEN-1:0]   rdata;
    logic [SHADOW_XLEN-1:0]   wdata;
    logic [SHADOW_MASK_W-1:0] rmask;
    logic [SHADOW_MASK_W-1:0] wmask;
  } shadow_mem_t;

  typedef struct packed {
    logic                   valid;
    logic [SHADOW_XLEN-1:0] inst;
    logic [SHADOW_XLEN-1:0] pc_rdata;
    logic [SHADOW_XLEN-1:0] pc_wdata;
    logic [SHADOW_XLEN-1:0] rs1_rdata;
    logic [SHADOW_XLEN-1:0] rs2_rdata;
    logic [4:0]             rs1_addr;
    logic [4:0]             rs2_addr;
    logic [4:0]             rd_addr;
    logic                   load_regfile;
    shadow_mem_t            mem;
  } shadow_entry_t;

endpackage

// File: rtl/rvfi_shadow_stage.sv
// rtl/rvfi_shadow_stage.sv - one shadow pipeline stage register
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   advance     pipeline moves this cycle
//   prev_kill   flush of the upstream stage: its entry arrives here invalid
//   self_kill   flush of this stage: clears valid in place while held
//   mem_sel     this stage takes mem_in instead of the shifted memory fields
//   prev        upstream entry (capture entry for stage 0)
//   mem_in      live memory-side fields
//   cur         stored entry

module rvfi_shadow_stage
  import rvfi_shadow_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          prev_kill,
  input  logic          self_kill,
  input  logic          mem_sel,
  input  shadow_entry_t prev,
  input  shadow_mem_t   mem_in,
  output shadow_entry_t cur
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= '0;
    end else if (advance) begin
      cur       <= prev;
      cur.valid <= prev.valid & ~prev_kill;
      if (mem_sel) begin
        cur.mem <= mem_in;
      end
    end else if (self_kill) begin
      // Held entry is squashed; its fields stay but it will never commit.
      cur.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rvfi_shadow_pipe.sv
// rtl/rvfi_shadow_pipe.sv - RVFI shadow pipeline from capture point to commit
//
// Optional feature macro: RVFI_SHADOW_PCCHK_EN (PC continuity checker).
//
// Parameters: STAGES (2..8), MEM_STAGE (1..STAGES-1), XLEN (= SHADOW_XLEN).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   advance             pipeline moves this cycle
//   flush[STAGES]       per-stage kill
//   cap_*               stage-0 capture (issue-side fields)
//   mem_*               memory fields for the entry in stage MEM_STAGE-1
//   rd_wdata            live writeback value, passed straight to out_rd_wdata
//   commit, order       retirement strobe and retirement index
//   halt                committing instruction jumps to itself
//   pc_err              sticky PC discontinuity flag (0 unless checker built)
//   out_*               fields of the entry in stage STAGES-1

module rvfi_shadow_pipe
  import rvfi_shadow_pkg::*;
#(
  parameter int STAGES    = 3,
  parameter int MEM_STAGE = 2,
  parameter int XLEN      = SHADOW_XLEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                advance,
  input  logic [STAGES-1:0]   flush,
  input  logic                cap_valid,
  input  logic [XLEN-1:0]     cap_inst,
  input  logic [XLEN-1:0]     cap_pc_rdata,
  input  logic [XLEN-1:0]     cap_pc_wdata,
  input  logic [XLEN-1:0]     cap_rs1_rdata,
  input  logic [XLEN-1:0]     cap_rs2_rdata,
  input  logic [4:0]          cap_rs1_addr,
  input  logic [4:0]          cap_rs2_addr,
  input  logic [4:0]          cap_rd_addr,
  input  logic                cap_load_regfile,
  input  logic [XLEN-1:0]     mem_addr,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN/8-1:0]   mem_rmask,
  input  logic [XLEN/8-1:0]   mem_wmask,
  input  logic [XLEN-1:0]     rd_wdata,
  output logic                commit,
  output logic [ORDER_W-1:0]  order,
  output logic                halt,
  output logic                pc_err,
  output logic [XLEN-1:0]     out_inst,
  output logic [XLEN-1:0]     out_pc_rdata,
  output logic [XLEN-1:0]     out_pc_wdata,
  output logic [XLEN-1:0]     out_rs1_rdata,
  output logic [XLEN-1:0]     out_rs2_rdata,
  output logic [4:0]          out_rs1_addr,
  output logic [4:0]          out_rs2_addr,
  output logic [4:0]          out_rd_addr,
  output logic                out_load_regfile,
  output logic [XLEN-1:0]     out_mem_addr,
  output logic [XLEN-1:0]     out_mem_rdata,
  output logic [XLEN-1:0]     out_mem_wdata,
  output logic [XLEN/8-1:0]   out_mem_rmask,
  output logic [XLEN/8-1:0]   out_mem_wmask,
  output logic [XLEN-1:0]     out_rd_wdata
);

  shadow_entry_t cap_entry;
  shadow_mem_t   mem_in;
  shadow_entry_t stage_q [STAGES];
  shadow_entry_t last;

  always_comb begin
    cap_entry              = '0;
    cap_entry.valid        = cap_valid;
    cap_entry.inst         = cap_inst;
    cap_entry.pc_rdata     = cap_pc_rdata;
    cap_entry.pc_wdata     = cap_pc_wdata;
    cap_entry.rs1_rdata    = cap_rs1_rdata;
    cap_entry.rs2_rdata    = cap_rs2_rdata;
    cap_entry.rs1_addr     = cap_rs1_addr;
    cap_entry.rs2_addr     = cap_rs2_addr;
    cap_entry.rd_addr      = cap_rd_addr;
    cap_entry.load_regfile = cap_load_regfile;
  end

  always_comb begin
    mem_in       = '0;
    mem_in.addr  = mem_addr;
    mem_in.rdata = mem_rdata;
    mem_in.wdata = mem_wdata;
    mem_in.rmask = mem_rmask;
    mem_in.wmask = mem_wmask;
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    shadow_entry_t prev;
    logic          prev_kill;

    if (i == 0) begin : g_head
      // A stage-0 flush only squashes what is already there, never the
      // instruction being captured on this edge.
      assign prev      = cap_entry;
      assign prev_kill = 1'b0;
    end else begin : g_body
      assign prev      = stage_q[i-1];
      assign prev_kill = flush[i-1];
    end

    rvfi_shadow_stage u_stage (
      .clk       (clk),
      .rst       (rst),
      .advance   (advance),
      .prev_kill (prev_kill),
      .self_kill (flush[i]),
      .mem_sel   (i == MEM_STAGE),
      .prev      (prev),
      .mem_in    (mem_in),
      .cur       (stage_q[i])
    );
  end

  assign last = stage_q[STAGES-1];

  assign commit = last.valid & advance;
  assign halt   = commit & (last.pc_rdata == last.pc_wdata);

  // Presented value is the pre-increment count; wraps at 2^64 naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      order <= '0;
    end else if (commit) begin
      order <= order + 1'b1;
    end
  end

  assign out_inst         = last.inst;
  assign out_pc_rdata     = last.pc_rdata;
  assign out_pc_wdata     = last.pc_wdata;
  assign out_rs1_rdata    = last.rs1_rdata;
  assign out_rs2_rdata    = last.rs2_rdata;
  assign out_rs1_addr     = last.rs1_addr;
  assign out_rs2_addr     = last.rs2_addr;
  assign out_rd_addr      = last.rd_addr;
  assign out_load_regfile = last.load_regfile;
  assign out_mem_addr     = last.mem.addr;
  assign out_mem_rdata    = last.mem.rdata;
  assign out_mem_wdata    = last.mem.wdata;
  assign out_mem_rmask    = last.mem.rmask;
  assign out_mem_wmask    = last.mem.wmask;
  assign out_rd_wdata     = rd_wdata;

`ifdef RVFI_SHADOW_PCCHK_EN
  logic [XLEN-1:0] last_pc_wdata;
  logic            seen_commit;
  logic            pc_err_q;

  // The first commit after reset has no predecessor to compare against.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pc_wdata <= '0;
      seen_commit   <= 1'b0;
      pc_err_q      <= 1'b0;
    end else if (commit) begin
      last_pc_wdata <= last.pc_wdata;
      seen_commit   <= 1'b1;
      if (seen_commit && (last.pc_rdata != last_pc_wdata)) begin
        pc_err_q <= 1'b1;
      end
    end
  end

  assign pc_err = pc_err_q;
`else
  assign pc_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_shadow_pipe.sv
// tb/tb_rvfi_shadow_pipe.sv - directed self-checking bench for rvfi_shadow_pipe

module tb_rvfi_shadow_pipe;

  localparam int STAGES = 3;
  localparam int XLEN   = 32;

`ifdef RVFI_SHADOW_PCCHK_EN
  localparam logic PCCHK = 1'b1;
`else
  localparam logic PCCHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              advance;
  logic [STAGES-1:0] flush;
  logic              cap_valid;
  logic [XLEN-1:0]   cap_inst, cap_pc_rdata, cap_pc_wdata, cap_rs1_rdata, cap_rs2_rdata;
  logic [4:0]        cap_rs1_addr, cap_rs2_addr, cap_rd_addr;
  logic              cap_load_regfile;
  logic [XLEN-1:0]   mem_addr, mem_rdata, mem_wdata;
  logic [XLEN/8-1:0] mem_rmask, mem_wmask;
  logic [XLEN-1:0]   rd_wdata;
  logic              commit, halt, pc_err;
  logic [63:0]       order;
  logic [XLEN-1:0]   out_inst, out_pc_rdata, out_pc_wdata, out_rs1_rdata, out_rs2_rdata;
  logic [4:0]        out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic              out_load_regfile;
  logic [XLEN-1:0]   out_mem_addr, out_mem_rdata, out_mem_wdata;
  logic [XLEN/8-1:0] out_mem_rmask, out_mem_wmask;
  logic [XLEN-1:0]   out_rd_wdata;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rvfi_shadow_pipe #(.STAGES(STAGES), .MEM_STAGE(2), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .advance(advance), .flush(flush),
    .cap_valid(cap_valid), .cap_inst(cap_inst), .cap_pc_rdata(cap_pc_rdata),
    .cap_pc_wdata(cap_pc_wdata), .cap_rs1_rdata(cap_rs1_rdata), .cap_rs2_rdata(cap_rs2_rdata),
    .cap_rs1_addr(cap_rs1_addr), .cap_rs2_addr(cap_rs2_addr), .cap_rd_addr(cap_rd_addr),
    .cap_load_regfile(cap_load_regfile),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .rd_wdata(rd_wdata),
    .commit(commit), .order(order), .halt(halt), .pc_err(pc_err),
    .out_inst(out_inst), .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata),
    .out_rs1_rdata(out_rs1_rdata), .out_rs2_rdata(out_rs2_rdata),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
    .out_load_regfile(out_load_regfile),
    .out_mem_addr(out_mem_addr), .out_mem_rdata(out_mem_rdata), .out_mem_wdata(out_mem_wdata),
    .out_mem_rmask(out_mem_rmask), .out_mem_wmask(out_mem_wmask), .out_rd_wdata(out_rd_wdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pc_of(input int k);
    return 32'h0000_1000 + 32'(k) * 32'd16;
  endfunction

  task automatic drive_cap(input int k);
    cap_valid        = 1'b1;
    cap_inst         = 32'hA000_0000 + 32'(k);
    cap_pc_rdata     = pc_of(k);
    cap_pc_wdata     = pc_of(k) + 32'd4;
    cap_rs1_rdata    = 32'h1100_0000 + 32'(k);
    cap_rs2_rdata    = 32'h2200_0000 + 32'(k);
    cap_rs1_addr     = 5'(k);
    cap_rs2_addr     = 5'(k + 1);
    cap_rd_addr      = 5'(k + 2);
    cap_load_regfile = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; advance = 1'b0; flush = '0; cap_valid = 1'b0;
    cap_inst = '0; cap_pc_rdata = '0; cap_pc_wdata = '0; cap_rs1_rdata = '0; cap_rs2_rdata = '0;
    cap_rs1_addr = '0; cap_rs2_addr = '0; cap_rd_addr = '0; cap_load_regfile = 1'b0;
    mem_addr = '0; mem_rdata = '0; mem_wdata = '0; mem_rmask = '0; mem_wmask = '0;
    rd_wdata = '0;

    // Reset state
    tick(); tick();
    check("rst_commit", 64'(commit), 64'd0);
    check("rst_order", order, 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_pc_err", 64'(pc_err), 64'd0);
    check("rst_out_pc", 64'(out_pc_rdata), 64'd0);
    rst = 1'b0;
    rd_wdata = 32'hDEAD_BEEF;
    #1;
    check("rd_wdata_pass", 64'(out_rd_wdata), 64'hDEAD_BEEF);

    // Back-to-back capture: first commit after third edge, order consecutive
    advance = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      drive_cap(e);
      tick();
      if (e < 3) begin
        check($sformatf("fill_commit_e%0d", e), 64'(commit), 64'd0);
      end else begin
        check($sformatf("run_commit_e%0d", e), 64'(commit), 64'd1);
        check($sformatf("run_order_e%0d", e), order, 64'(e - 3));
        check($sformatf("run_pc_e%0d", e), 64'(out_pc_rdata), 64'(pc_of(e - 2)));
      end
    end
    check("run_inst", 64'(out_inst), 64'hA000_0003);
    check("run_rd_addr", 64'(out_rd_addr), 64'd5);

    // Pause for 4 cycles with a valid entry at the last stage
    advance = 1'b0;
    drive_cap(99);
    #1;
    check("stall_commit_now", 64'(commit), 64'd0);
    for (int s = 0; s < 4; s++) begin
      tick();
      check($sformatf("stall_commit_%0d", s), 64'(commit), 64'd0);
      check($sformatf("stall_order_%0d", s), order, 64'd2);
      check($sformatf("stall_pc_%0d", s), 64'(out_pc_rdata), 64'(pc_of(3)));
    end
    advance = 1'b1;
    drive_cap(6);
    #1;
    check("resume_commit", 64'(commit), 64'd1);
    check("resume_order", order, 64'd2);
    tick();
    check("resume_order_next", order, 64'd3);
    check("resume_pc_next", 64'(out_pc_rdata), 64'(pc_of(4)));

    // Taken branch in the last stage squashes the two younger entries
    flush = 3'b011;
    drive_cap(7);
    tick();
    flush = '0;
    check("br_commit_a", 64'(commit), 64'd0);
    check("br_order_a", order, 64'd4);
    drive_cap(8);
    tick();
    check("br_commit_b", 64'(commit), 64'd0);
    check("br_order_b", order, 64'd4);
    drive_cap(9);
    tick();
    check("br_commit_c", 64'(commit), 64'd1);
    check("br_order_c", order, 64'd4);
    check("br_pc_c", 64'(out_pc_rdata), 64'(pc_of(7)));
    check("br_halt_c", 64'(halt), 64'd0);

    // Self-loop entry gives halt; memory fields injected while it is in stage 1
    drive_cap(10);
    cap_pc_rdata = 32'h0000_0100;
    cap_pc_wdata = 32'h0000_0100;
    tick();
    check("h_halt_prev", 64'(halt), 64'd0);
    drive_cap(11);
    tick();
    mem_addr  = 32'h0000_2000;
    mem_wmask = 4'b1100;
    drive_cap(12);
    tick();
    mem_addr  = '0;
    mem_wmask = '0;
    check("h_commit", 64'(commit), 64'd1);
    check("h_halt", 64'(halt), 64'd1);
    check("h_order", order, 64'd7);
    check("h_pc", 64'(out_pc_rdata), 64'h100);
    check("m_addr", 64'(out_mem_addr), 64'h2000);
    check("m_wmask", 64'(out_mem_wmask), 64'hC);
    drive_cap(13);
    tick();
    check("h_halt_after", 64'(halt), 64'd0);
    check("m_addr_after", 64'(out_mem_addr), 64'd0);
    check("h_pc_after", 64'(out_pc_rdata), 64'(pc_of(11)));

    // Flush of a held last-stage entry clears it in place
    advance = 1'b0;
    flush = 3'b100;
    tick();
    flush = '0;
    advance = 1'b1;
    #1;
    check("hflush_commit", 64'(commit), 64'd0);
    check("hflush_order", order, 64'd8);
    drive_cap(14);
    tick();
    check("hflush_next_commit", 64'(commit), 64'd1);
    check("hflush_next_pc", 64'(out_pc_rdata), 64'(pc_of(12)));
    check("hflush_next_order", order, 64'd8);

    // Asynchronous reset mid-stream, away from the clock edge
    #2;
    rst = 1'b1;
    #1;
    check("arst_commit", 64'(commit), 64'd0);
    check("arst_order", order, 64'd0);
    check("arst_out_pc", 64'(out_pc_rdata), 64'd0);

    // PC continuity: 0x00->0x04 then 0x08
    tick();
    rst = 1'b0;
    advance = 1'b1;
    drive_cap(0);
    cap_pc_rdata = 32'h0;
    cap_pc_wdata = 32'h4;
    tick();
    drive_cap(0);
    cap_pc_rdata = 32'h8;
    cap_pc_wdata = 32'hC;
    tick();
    cap_valid = 1'b0;
    tick();
    check("pc_a_commit", 64'(commit), 64'd1);
    check("pc_a_order", order, 64'd0);
    check("pc_a_err", 64'(pc_err), 64'd0);
    check("pc_a_halt", 64'(halt), 64'd0);
    tick();
    check("pc_b_order", order, 64'd1);
    check("pc_b_err", 64'(pc_err), 64'd0);
    tick();
    check("pc_err_set", 64'(pc_err), 64'(PCCHK));
    check("pc_idle_commit", 64'(commit), 64'd0);
    tick(); tick();
    check("pc_err_sticky", 64'(pc_err), 64'(PCCHK));
    rst = 1'b1;
    #1;
    check("pc_err_rst", 64'(pc_err), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rvfi_shadow_pipe.md
RVFI_SHADOW_PIPE -- requirements
Module: rvfi_shadow_pipe

Interface
REQ-001 Parameter STAGES, default 3: pipeline stages from capture point to commit point; legal 2..8.
REQ-002 Parameter MEM_STAGE, default 2: stage index receiving memory-side fields; legal 1..STAGES-1.
REQ-003 Parameter XLEN, default 32: data/address width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 advance  in  1  pipeline moves this cycle (inverse of pause).
REQ-007 flush  in  STAGES  per-stage kill; bit i kills the entry in stage i.
REQ-008 cap_valid  in  1  stage-0 capture carries a real instruction.
REQ-009 cap_inst, cap_pc_rdata, cap_pc_wdata, cap_rs1_rdata, cap_rs2_rdata  in  XLEN each  issue-side fields.
REQ-010 cap_rs1_addr, cap_rs2_addr, cap_rd_addr  in  5 each; cap_load_regfile  in  1.
REQ-011 mem_addr, mem_rdata, mem_wdata  in  XLEN; mem_rmask, mem_wmask  in  XLEN/8  memory fields for the entry in stage MEM_STAGE-1.
REQ-012 rd_wdata  in  XLEN  live writeback value, passed through at commit.
REQ-013 commit  out  1; order  out  64; halt  out  1; pc_err  out  1.
REQ-014 out_* outputs, one per captured/memory field, same widths, reflecting stage STAGES-1.

Function
REQ-015 Each stage SHALL hold one entry: valid bit plus all captured and memory fields.
REQ-016 On a rising edge with advance=1, stage i SHALL load stage i-1 (i>=1) and stage 0 SHALL load cap_* with valid=cap_valid.
REQ-017 On that edge, stage MEM_STAGE SHALL take mem_* inputs in place of the shifted memory fields; all other fields shift unchanged.
REQ-018 On a rising edge with advance=0, every field SHALL hold except valid bits cleared by flush.
REQ-019 flush[i]=1 SHALL cause the entry in stage i to not propagate: stage i+1 receives valid=0 if advance=1, else stage i valid clears in place.
REQ-020 flush[0] with advance=1 SHALL NOT block the new capture into stage 0.
REQ-021 commit SHALL be combinational: valid of stage STAGES-1 AND advance.
REQ-022 order SHALL equal the number of commits since reset; it increments by 1 on each edge where commit=1, and the value presented during a commit is the pre-increment value.
REQ-023 order SHALL wrap modulo 2^64.
REQ-024 halt SHALL be combinational: commit AND out_pc_rdata==out_pc_wdata.
REQ-025 Zero-latency property: an instruction captured at edge N with advance held high commits during cycle N+STAGES-1.
REQ-026 out_rd_wdata SHALL equal rd_wdata combinationally; all other out_* are registered.

Reset
REQ-027 While rst=1 all valid bits, order, pc_err and stored fields SHALL be 0; commit and halt therefore 0.
REQ-028 rst asserted mid-stream SHALL drop all in-flight entries immediately, without waiting for clk.

Configuration
REQ-029 Macro RVFI_SHADOW_PCCHK_EN defined: a register SHALL hold the last committed out_pc_wdata; pc_err SHALL set (sticky until reset) on a commit whose out_pc_rdata differs, the first commit after reset exempt.
REQ-030 Macro undefined: pc_err SHALL be constant 0 and no tracking register synthesised.

Structure
REQ-031 Package rvfi_shadow_pkg SHALL hold the entry struct typedef (parametrised by XLEN via localparam defaults) and the ORDER_W=64 constant.
REQ-032 One stage register SHALL be sub-module rvfi_shadow_stage (shift/hold/flush/mem-override), instantiated STAGES times via generate.

Verification
REQ-033 Reset release, cap_valid=1 every cycle, advance=1, STAGES=3: first commit at third edge after capture, order 0,1,2... consecutive.
REQ-034 advance low 4 cycles with valid entry at last stage: commit=0 throughout, order unchanged, outputs held; commit resumes on release.
REQ-035 flush=3'b011 on a taken branch: two younger entries never commit; order has no gap.
REQ-036 Entry with pc_rdata=pc_wdata=0x0000_0100 committing: halt=1 in that cycle only.
REQ-037 mem_wmask=4'b1100, mem_addr=0x0000_2000 driven when entry in stage 1: same values on out_mem_* at that entry's commit.
REQ-038 With RVFI_SHADOW_PCCHK_EN, commits pc 0x00→wdata 0x04 then pc_rdata 0x08: pc_err rises and stays 1 until rst.
